// File: rtl/dram_dmaarb_pkg.sv
// ============================================================================
// Module      : dram_dmaarb_pkg
// Description : Shared FSM encodings and DRAM constants for the DMA arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_dmaarb_pkg;

  localparam int DMAARB_AW_DEFAULT = 21;

  // Byte-select encoding {hi,lo}, common with the main DRAM arbiter
  localparam logic [1:0] DMAARB_BSEL_NONE = 2'b00;
  localparam logic [1:0] DMAARB_BSEL_LO   = 2'b01;
  localparam logic [1:0] DMAARB_BSEL_HI   = 2'b10;
  localparam logic [1:0] DMAARB_BSEL_WORD = 2'b11;

  typedef enum logic [0:0] {
    DMAARB_IDLE  = 1'b0,
    DMAARB_ISSUE = 1'b1
  } dmaarb_state_e;

endpackage

`default_nettype wire

// File: rtl/dram_dmaarb_if.sv
// ============================================================================
// Module      : dmaarb_req_if / dmaarb_dram_if
// Description : Master-side and DRAM-side handshake bundles of the DMA arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmaarb_req_if
  import dram_dmaarb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = DMAARB_AW_DEFAULT
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    rnw;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*16-1:0] wrdata;
  logic [NREQ*2-1:0]  bsel;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    rdstb;
  logic [15:0]        rddata;

  modport master (output req, rnw, addr, wrdata, bsel, input ack, rdstb, rddata);
  modport slave  (input req, rnw, addr, wrdata, bsel, output ack, rdstb, rddata);
endinterface

interface dmaarb_dram_if
  import dram_dmaarb_pkg::*;
#(
  parameter int AW = DMAARB_AW_DEFAULT
);
  logic          dma_req;
  logic          dma_rnw;
  logic [AW-1:0] dma_addr;
  logic [15:0]   dma_wrdata;
  logic [1:0]    dma_bsel;
  logic          dma_next;
  logic          dma_strobe;
  logic [15:0]   dma_rddata;

  modport master (output dma_req, dma_rnw, dma_addr, dma_wrdata, dma_bsel,
                  input  dma_next, dma_strobe, dma_rddata);
  modport slave  (input  dma_req, dma_rnw, dma_addr, dma_wrdata, dma_bsel,
                  output dma_next, dma_strobe, dma_rddata);
endinterface

`default_nettype wire

// File: rtl/dram_dmaarb_tagfifo.sv
// ============================================================================
// Module      : dmaarb_tagfifo
// Description : Tag FIFO of requester indices for outstanding DRAM reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmaarb_tagfifo #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         fclk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign head  = mem_q[rd_q];

  // A pop on an empty FIFO is dropped; a push into a full FIFO needs a pop alongside
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = nxt(wr_q);
    end
    if (do_pop) begin
      rd_d = nxt(rd_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dram_dmaarb.sv
// ============================================================================
// Module      : dram_dmaarb
// Description : Round-robin arbiter for the DRAM spare-cycle port with read
//               tag tracking. Define DMAARB_FIXPRIO_EN for fixed priority
//               (lowest index wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_dmaarb
  import dram_dmaarb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = DMAARB_AW_DEFAULT,
  parameter int TAGD = 2
) (
  input  logic          fclk,
  input  logic          rst_n,
  dmaarb_req_if.slave   mst,
  dmaarb_dram_if.master dram,
  output logic          err
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  dmaarb_state_e   state_q, state_d;
  logic [IW-1:0]   cur_q, cur_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] rdstb_q, rdstb_d;
  logic [15:0]     rddata_q, rddata_d;
  logic            dma_req_q, dma_req_d;
  logic            dma_rnw_q, dma_rnw_d;
  logic [AW-1:0]   dma_addr_q, dma_addr_d;
  logic [15:0]     dma_wrdata_q, dma_wrdata_d;
  logic [1:0]      dma_bsel_q, dma_bsel_d;
  logic            err_q, err_d;
  logic            fifo_push, fifo_full, fifo_empty;
  logic [IW-1:0]   fifo_head;
  logic [IW-1:0]   win;

`ifdef DMAARB_FIXPRIO_EN
  function automatic logic [IW-1:0] pick_fixed(input logic [NREQ-1:0] r);
    logic [IW-1:0] res;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r[IW'(i)]) res = IW'(i);
    end
    return res;
  endfunction

  assign win = pick_fixed(mst.req);
`else
  logic [IW-1:0] ptr_q, ptr_d;

  // Scan downward from the farthest candidate so the nearest one after p wins
  function automatic logic [IW-1:0] pick_rr(input logic [NREQ-1:0] r,
                                             input logic [IW-1:0]   p);
    logic [IW-1:0] res;
    int            idx;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(p) + i) % NREQ;
      if (r[IW'(idx)]) res = IW'(idx);
    end
    return res;
  endfunction

  assign win = pick_rr(mst.req, ptr_q);
`endif

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    ack_d        = '0;
    rdstb_d      = '0;
    rddata_d     = rddata_q;
    dma_req_d    = dma_req_q;
    dma_rnw_d    = dma_rnw_q;
    dma_addr_d   = dma_addr_q;
    dma_wrdata_d = dma_wrdata_q;
    dma_bsel_d   = dma_bsel_q;
    err_d        = err_q;
    fifo_push    = 1'b0;
`ifndef DMAARB_FIXPRIO_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      DMAARB_IDLE: begin
        if ((|mst.req) && !fifo_full) begin
          cur_d        = win;
          dma_req_d    = 1'b1;
          dma_rnw_d    = mst.rnw[win];
          dma_addr_d   = mst.addr[int'(win)*AW +: AW];
          dma_wrdata_d = mst.wrdata[int'(win)*16 +: 16];
          dma_bsel_d   = mst.bsel[int'(win)*2 +: 2];
          state_d      = DMAARB_ISSUE;
        end
      end
      DMAARB_ISSUE: begin
        if (dram.dma_next) begin
          dma_req_d    = 1'b0;
          ack_d[cur_q] = 1'b1;
          fifo_push    = dma_rnw_q;
`ifndef DMAARB_FIXPRIO_EN
          ptr_d        = cur_q;
`endif
          state_d      = DMAARB_IDLE;
        end
      end
      default: state_d = DMAARB_IDLE;
    endcase
    // Returning read data always belongs to the oldest outstanding tag
    if (dram.dma_strobe) begin
      if (!fifo_empty) begin
        rdstb_d[fifo_head] = 1'b1;
        rddata_d           = dram.dma_rddata;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DMAARB_IDLE;
      cur_q        <= '0;
      ack_q        <= '0;
      rdstb_q      <= '0;
      rddata_q     <= '0;
      dma_req_q    <= 1'b0;
      dma_rnw_q    <= 1'b1;
      dma_addr_q   <= '0;
      dma_wrdata_q <= '0;
      dma_bsel_q   <= DMAARB_BSEL_NONE;
      err_q        <= 1'b0;
`ifndef DMAARB_FIXPRIO_EN
      ptr_q        <= IW'(NREQ - 1);
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      ack_q        <= ack_d;
      rdstb_q      <= rdstb_d;
      rddata_q     <= rddata_d;
      dma_req_q    <= dma_req_d;
      dma_rnw_q    <= dma_rnw_d;
      dma_addr_q   <= dma_addr_d;
      dma_wrdata_q <= dma_wrdata_d;
      dma_bsel_q   <= dma_bsel_d;
      err_q        <= err_d;
`ifndef DMAARB_FIXPRIO_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  dmaarb_tagfifo #(
    .DEPTH (TAGD),
    .W     (IW)
  ) u_tagfifo (
    .fclk  (fclk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (dram.dma_strobe),
    .din   (cur_q),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign mst.ack         = ack_q;
  assign mst.rdstb       = rdstb_q;
  assign mst.rddata      = rddata_q;
  assign dram.dma_req    = dma_req_q;
  assign dram.dma_rnw    = dma_rnw_q;
  assign dram.dma_addr   = dma_addr_q;
  assign dram.dma_wrdata = dma_wrdata_q;
  assign dram.dma_bsel   = dma_bsel_q;
  assign err             = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_dmaarb.sv
// ============================================================================
// Module      : tb_dram_dmaarb
// Description : Self-checking bench for dram_dmaarb (honours DMAARB_FIXPRIO_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_dmaarb;
  import dram_dmaarb_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 21;
  localparam int TAGD = 2;

  logic fclk  = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  int n_checks = 0;
  int n_pass   = 0;

  dmaarb_req_if  #(.NREQ(NREQ), .AW(AW)) mif ();
  dmaarb_dram_if #(.AW(AW))              dif ();

  dram_dmaarb #(.NREQ(NREQ), .AW(AW), .TAGD(TAGD)) dut (
    .fclk  (fclk),
    .rst_n (rst_n),
    .mst   (mif),
    .dram  (dif),
    .err   (err)
  );

  always #5 fclk = ~fclk;

  // Reference model: transaction-level view with a queue of outstanding read owners
  bit              m_busy;
  int              m_cur, m_ptr;
  int              m_tags[$];
  logic            m_rnw;
  logic [AW-1:0]   m_addr;
  logic [15:0]     m_wd;
  logic [1:0]      m_bs;
  logic [NREQ-1:0] m_ack, m_rdstb;
  logic [15:0]     m_rddata;
  logic            m_err;

  int ack_log[$];
  int rd_log[$];

  task automatic model_reset();
    m_busy = 0; m_cur = 0; m_ptr = NREQ - 1; m_tags.delete();
    m_rnw = 1'b1; m_addr = '0; m_wd = '0; m_bs = '0;
    m_ack = '0; m_rdstb = '0; m_rddata = '0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int occ, w, c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    occ = m_tags.size();
    m_ack = '0;
    m_rdstb = '0;
    if (dif.dma_strobe) begin
      if (occ > 0) begin
        m_rdstb[m_tags[0]] = 1'b1;
        m_rddata = dif.dma_rddata;
        void'(m_tags.pop_front());
      end else begin
        m_err = 1'b1;
      end
    end
    if (m_busy) begin
      if (dif.dma_next) begin
        m_ack[m_cur] = 1'b1;
        m_ptr = m_cur;
        if (m_rnw) m_tags.push_back(m_cur);
        m_busy = 0;
      end
    end else if (mif.req != '0 && occ < TAGD) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
`ifdef DMAARB_FIXPRIO_EN
        c = k - 1;
`else
        c = (m_ptr + k) % NREQ;
`endif
        if (w < 0 && mif.req[c]) w = c;
      end
      m_cur  = w;
      m_rnw  = mif.rnw[w];
      m_addr = mif.addr[w*AW +: AW];
      m_wd   = mif.wrdata[w*16 +: 16];
      m_bs   = mif.bsel[w*2 +: 2];
      m_busy = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h @%0t", nm, act, exp, $time);
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: model consumes the inputs the DUT will sample, then outputs are compared
  task automatic tick();
    model_step();
    @(posedge fclk);
    #1;
    chk("ack",        mif.ack,        m_ack);
    chk("rdstb",      mif.rdstb,      m_rdstb);
    chk("rddata",     mif.rddata,     m_rddata);
    chk("dma_req",    dif.dma_req,    m_busy);
    chk("dma_rnw",    dif.dma_rnw,    m_rnw);
    chk("dma_addr",   dif.dma_addr,   m_addr);
    chk("dma_wrdata", dif.dma_wrdata, m_wd);
    chk("dma_bsel",   dif.dma_bsel,   m_bs);
    chk("err",        err,            m_err);
    if (mif.ack != '0)   ack_log.push_back(onehot_idx(mif.ack));
    if (mif.rdstb != '0) rd_log.push_back(onehot_idx(mif.rdstb));
  endtask

  task automatic clear_inputs();
    mif.req = '0; mif.rnw = '0; mif.addr = '0; mif.wrdata = '0; mif.bsel = '0;
    dif.dma_next = 1'b0; dif.dma_strobe = 1'b0; dif.dma_rddata = '0;
  endtask

  task automatic set_master(input int i, input logic rnw, input logic [AW-1:0] a,
                            input logic [15:0] wd, input logic [1:0] bs);
    mif.rnw[i] = rnw;
    mif.addr[i*AW +: AW] = a;
    mif.wrdata[i*16 +: 16] = wd;
    mif.bsel[i*2 +: 2] = bs;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    model_reset();

    // Reset values
    do_reset();
    chk("rst_dma_rnw", dif.dma_rnw, 1);
    chk("rst_dma_req", dif.dma_req, 0);
    chk("rst_err", err, 0);

    // Single write from master 2
    set_master(2, 1'b0, 21'h0ABCD, 16'hBEEF, 2'b01);
    mif.req = 4'b0100;
    tick();
    chk("w1_dma_req", dif.dma_req, 1);
    chk("w1_dma_addr", dif.dma_addr, 21'h0ABCD);
    chk("w1_dma_bsel", dif.dma_bsel, 2'b01);
    chk("w1_dma_rnw", dif.dma_rnw, 0);
    repeat (5) tick();
    dif.dma_next = 1'b1;
    tick();
    dif.dma_next = 1'b0;
    chk("w1_ack", mif.ack, 4'b0100);
    mif.req = '0;
    tick();
    chk("w1_ack_one_cycle", mif.ack, 4'b0000);
    chk("w1_req_drop", dif.dma_req, 0);
    // Write left nothing outstanding: a strobe is an error
    dif.dma_strobe = 1'b1;
    tick();
    dif.dma_strobe = 1'b0;
    chk("w1_empty_err", err, 1);
    chk("w1_empty_rdstb", mif.rdstb, 4'b0000);
    repeat (3) tick();
    chk("w1_err_sticky", err, 1);

    // Round robin with all masters requesting writes
    do_reset();
    for (int i = 0; i < NREQ; i++) set_master(i, 1'b0, AW'(i * 256), 16'(i), 2'b11);
    mif.req = 4'b1111;
    ack_log.delete();
    for (int g = 0; g < 8; g++) begin
      repeat (7) tick();
      dif.dma_next = 1'b1;
      tick();
      dif.dma_next = 1'b0;
    end
    mif.req = '0;
    tick();
    chk("rr_count", ack_log.size(), 8);
    for (int g = 0; g < 8 && g < ack_log.size(); g++) begin
`ifdef DMAARB_FIXPRIO_EN
      chk("rr_order", ack_log[g], 0);
`else
      chk("rr_order", ack_log[g], g % NREQ);
`endif
    end

    // Pipelined reads, full hold, simultaneous push/pop
    do_reset();
    set_master(1, 1'b1, 21'h11111, 16'h0, 2'b11);
    set_master(3, 1'b1, 21'h33333, 16'h0, 2'b11);
    mif.req = 4'b1010;
    tick();
    chk("pr_addr1", dif.dma_addr, 21'h11111);
    dif.dma_next = 1'b1;
    tick();
    dif.dma_next = 1'b0;
    chk("pr_ack1", mif.ack, 4'b0010);
    mif.req = 4'b1000;
    tick();
    chk("pr_addr3", dif.dma_addr, 21'h33333);
    dif.dma_next = 1'b1;
    tick();
    dif.dma_next = 1'b0;
    chk("pr_ack3", mif.ack, 4'b1000);
    set_master(0, 1'b1, 21'h00042, 16'h0, 2'b11);
    mif.req = 4'b0001;
    tick();
    tick();
    chk("pr_full_hold", dif.dma_req, 0);
    dif.dma_strobe = 1'b1;
    dif.dma_rddata = 16'h1111;
    tick();
    dif.dma_strobe = 1'b0;
    chk("pr_rdstb1", mif.rdstb, 4'b0010);
    chk("pr_rddata1", mif.rddata, 16'h1111);
    tick();
    chk("pr_third_issue", dif.dma_req, 1);
    dif.dma_next = 1'b1;
    dif.dma_strobe = 1'b1;
    dif.dma_rddata = 16'h3333;
    tick();
    dif.dma_next = 1'b0;
    dif.dma_strobe = 1'b0;
    chk("pp_ack0", mif.ack, 4'b0001);
    chk("pp_rdstb3", mif.rdstb, 4'b1000);
    chk("pp_rddata3", mif.rddata, 16'h3333);
    mif.req = '0;
    tick();
    chk("pp_rddata_hold", mif.rddata, 16'h3333);
    dif.dma_strobe = 1'b1;
    dif.dma_rddata = 16'h0A0A;
    tick();
    dif.dma_strobe = 1'b0;
    chk("pp_rdstb0", mif.rdstb, 4'b0001);
    chk("pp_rddata0", mif.rddata, 16'h0A0A);
    chk("pp_no_err", err, 0);

    // Withdrawn request still acknowledged; dma_next in IDLE ignored
    do_reset();
    set_master(1, 1'b0, 21'h00005, 16'h5555, 2'b10);
    mif.req = 4'b0010;
    tick();
    mif.req = '0;
    tick();
    tick();
    dif.dma_next = 1'b1;
    tick();
    chk("wd_ack1", mif.ack, 4'b0010);
    tick();
    dif.dma_next = 1'b0;
    chk("wd_idle_next_ack", mif.ack, 4'b0000);
    chk("wd_idle_next_req", dif.dma_req, 0);

    // Reset with two reads outstanding
    do_reset();
    set_master(0, 1'b1, 21'h00100, 16'h0, 2'b11);
    set_master(2, 1'b1, 21'h00200, 16'h0, 2'b11);
    set_master(1, 1'b1, 21'h00300, 16'h0, 2'b11);
    mif.req = 4'b0101;
    tick();
    dif.dma_next = 1'b1;
    tick();
    dif.dma_next = 1'b0;
    mif.req = 4'b0100;
    tick();
    dif.dma_next = 1'b1;
    tick();
    dif.dma_next = 1'b0;
    mif.req = 4'b0010;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mif.req = '0;
    tick();
    chk("rs_dma_req", dif.dma_req, 0);
    chk("rs_err", err, 0);
    dif.dma_strobe = 1'b1;
    tick();
    dif.dma_strobe = 1'b0;
    chk("rs_strobe_err", err, 1);
    chk("rs_strobe_rdstb", mif.rdstb, 4'b0000);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      mif.req    = NREQ'($urandom);
      mif.rnw    = NREQ'($urandom);
      mif.addr   = {$urandom, $urandom, $urandom};
      mif.wrdata = {$urandom, $urandom};
      mif.bsel   = NREQ*2'($urandom);
      dif.dma_next   = ($urandom_range(0, 2) == 0);
      dif.dma_strobe = (m_tags.size() > 0) ? ($urandom_range(0, 3) == 0)
                                            : ($urandom_range(0, 39) == 0);
      dif.dma_rddata = 16'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
